// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector for any 2..16-bit pattern. Mismatches follow the KMP
// failure transitions, and a saturating counter records how many matches were seen.
module seq_detect_param #(
   parameter int               PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
   parameter bit               OVERLAP = 1'b1,
   parameter bit               MOORE   = 1'b0,
   parameter int               CNT_W   = 8,
   localparam int              SW      = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i,
   input  logic             en,
   output logic             q,
   output logic [SW-1:0]    pst,
   output logic [SW-1:0]    nst,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam logic [SW-1:0] LAST = SW'(PAT_LEN - 1);

   // Bit of the pattern at receive position pos; position 0 is the first bit on the wire.
   function automatic logic pat_bit(input int pos);
      logic [PAT_LEN-1:0] sh;
      sh = PATTERN >> (PAT_LEN - 1 - pos);
      return sh[0];
   endfunction

   // Longest proper pattern prefix that is a suffix of (first k pattern bits, b).
   function automatic int kmp_next(input int k, input logic b);
      int   best;
      logic ok;
      logic sx;
      best = 0;
      for (int j = 1; j < PAT_LEN; j++) begin
         if (j <= k + 1) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
               sx = ((k + 1 - j + t) < k) ? pat_bit(k + 1 - j + t) : b;
               if (sx != pat_bit(t)) ok = 1'b0;
            end
            if (ok) best = j;
         end
      end
      return best;
   endfunction

   logic [SW-1:0]    nxt0 [2**SW];
   logic [SW-1:0]    nxt1 [2**SW];
   logic [SW-1:0]    pst_q;
   logic [SW-1:0]    nst_d;
   logic [CNT_W-1:0] cnt_q;
   logic             q_q;
   logic             match;

   for (genvar s = 0; s < 2**SW; s++) begin : g_tr
      localparam int N0 = (s < PAT_LEN) ? kmp_next(s, 1'b0) : 0;
      localparam int N1 = (s < PAT_LEN) ? kmp_next(s, 1'b1) : 0;
      assign nxt0[s] = SW'(N0);
      assign nxt1[s] = SW'(N1);
   end

   always_comb begin
      match = en & (pst_q == LAST) & (i == PATTERN[0]);
      nst_d = pst_q;
      if (en) nst_d = i ? nxt1[pst_q] : nxt0[pst_q];
      if (match && !OVERLAP) nst_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pst_q <= '0;
         cnt_q <= '0;
         q_q   <= 1'b0;
      end else begin
         pst_q <= nst_d;
         q_q   <= match;
         if (match && !cnt_sat) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign q         = MOORE ? q_q : match;
   assign pst       = pst_q;
   assign nst       = nst_d;
   assign match_cnt = cnt_q;
   assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: six parameter variants share one input stream and are
// compared every cycle against a history-based reference model, plus directed scenarios.
module tb_seq_detect_param;

   logic clk = 1'b0;
   logic rst, i, en;
   always #5 clk = ~clk;

   logic       q_a   [6];
   logic       sat_a [6];
   logic [1:0] pst_a [6];
   logic [1:0] nst_a [6];
   logic [7:0] cnt_a [6];
   logic [7:0] c0, c1, c2, c5;
   logic [1:0] c3;
   logic [2:0] c4;

   assign cnt_a[0] = c0;
   assign cnt_a[1] = c1;
   assign cnt_a[2] = c2;
   assign cnt_a[3] = 8'(c3);
   assign cnt_a[4] = 8'(c4);
   assign cnt_a[5] = c5;

   seq_detect_param u0 (.clk(clk), .rst(rst), .i(i), .en(en), .q(q_a[0]), .pst(pst_a[0]),
                        .nst(nst_a[0]), .match_cnt(c0), .cnt_sat(sat_a[0]));
   seq_detect_param #(.OVERLAP(1'b0)) u1 (.clk(clk), .rst(rst), .i(i), .en(en), .q(q_a[1]),
                        .pst(pst_a[1]), .nst(nst_a[1]), .match_cnt(c1), .cnt_sat(sat_a[1]));
   seq_detect_param #(.MOORE(1'b1)) u2 (.clk(clk), .rst(rst), .i(i), .en(en), .q(q_a[2]),
                        .pst(pst_a[2]), .nst(nst_a[2]), .match_cnt(c2), .cnt_sat(sat_a[2]));
   seq_detect_param #(.CNT_W(2)) u3 (.clk(clk), .rst(rst), .i(i), .en(en), .q(q_a[3]),
                        .pst(pst_a[3]), .nst(nst_a[3]), .match_cnt(c3), .cnt_sat(sat_a[3]));
   seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b111), .MOORE(1'b1), .CNT_W(3)) u4 (
                        .clk(clk), .rst(rst), .i(i), .en(en), .q(q_a[4]), .pst(pst_a[4]),
                        .nst(nst_a[4]), .match_cnt(c4), .cnt_sat(sat_a[4]));
   seq_detect_param #(.PATTERN(4'b1001)) u5 (.clk(clk), .rst(rst), .i(i), .en(en), .q(q_a[5]),
                        .pst(pst_a[5]), .nst(nst_a[5]), .match_cnt(c5), .cnt_sat(sat_a[5]));

   // Per-instance configuration, mirrored from the parameter overrides above.
   int          L    [6] = '{4, 4, 4, 4, 3, 4};
   logic [15:0] PATV [6] = '{16'hA, 16'hA, 16'hA, 16'hA, 16'h7, 16'h9};
   bit          OV   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   bit          MO   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   int          CMAX [6] = '{255, 255, 255, 3, 7, 255};

   logic [63:0] hist [6];
   int          hlen [6];
   int          cm   [6];
   logic        mq   [6];

   int nchk = 0;
   int nerr = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s got %0d want %0d", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] lowmask(input int n);
      return (64'd1 << n) - 64'd1;
   endfunction

   // Matched length = longest proper prefix of the pattern that ends the accepted history.
   function automatic int pstate(input int d, input logic [63:0] h, input int hl);
      int best;
      best = 0;
      for (int j = 1; j < L[d]; j++)
         if (hl >= j && ((h & lowmask(j)) == (64'(PATV[d]) >> (L[d] - j)))) best = j;
      return best;
   endfunction

   task automatic step(input logic b, input logic e, input logic r);
      logic [63:0] h2;
      int          hl2, st, nx;
      logic        m;
      @(negedge clk);
      i = b; en = e; rst = r;
      #1;
      for (int d = 0; d < 6; d++) begin
         st  = pstate(d, hist[d], hlen[d]);
         h2  = {hist[d][62:0], b};
         hl2 = (hlen[d] < 63) ? hlen[d] + 1 : 63;
         m   = e && (hl2 >= L[d]) && ((h2 & lowmask(L[d])) == 64'(PATV[d]));
         if (!e) nx = st;
         else if (m && !OV[d]) nx = 0;
         else nx = pstate(d, h2, hl2);
         check($sformatf("pst%0d", d), 32'(pst_a[d]), 32'(st));
         if (!r) check($sformatf("nst%0d", d), 32'(nst_a[d]), 32'(nx));
         if (MO[d]) check($sformatf("qmoore%0d", d), 32'(q_a[d]), 32'(mq[d]));
         else if (!r) check($sformatf("qmealy%0d", d), 32'(q_a[d]), 32'(m));
         check($sformatf("cnt%0d", d), 32'(cnt_a[d]), 32'(cm[d]));
         check($sformatf("sat%0d", d), 32'(sat_a[d]), 32'(cm[d] == CMAX[d]));
         if (r) begin
            hist[d] = '0; hlen[d] = 0; cm[d] = 0; mq[d] = 1'b0;
         end else begin
            if (e) begin
               if (m && !OV[d]) begin hist[d] = '0; hlen[d] = 0; end
               else begin hist[d] = h2; hlen[d] = hl2; end
            end
            if (m && cm[d] < CMAX[d]) cm[d]++;
            mq[d] = m;
         end
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] s2;
      int         e3 [5];
      logic [5:0] b5, e5;
      int         e6 [5];
      logic       rb, re, rr;

      for (int d = 0; d < 6; d++) begin
         hist[d] = '0; hlen[d] = 0; cm[d] = 0; mq[d] = 1'b0;
      end
      rst = 1'b1; i = 1'b0; en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 6; d++) begin
         check($sformatf("rst_pst%0d", d), 32'(pst_a[d]), 32'd0);
         check($sformatf("rst_cnt%0d", d), 32'(cnt_a[d]), 32'd0);
         check($sformatf("rst_sat%0d", d), 32'(sat_a[d]), 32'd0);
      end
      check("rst_qmoore", 32'(q_a[2]), 32'd0);

      // Overlapping 1010 stream: matches on bits 4 and 6.
      step(0, 0, 1);
      step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0);
      check("t1_q_bit4", 32'(q_a[0]), 32'd1);
      step(1, 1, 0); step(0, 1, 0);
      check("t1_q_bit6", 32'(q_a[0]), 32'd1);
      settle();
      check("t1_cnt", 32'(cnt_a[0]), 32'd2);

      // Non-overlapping detector restarts after each match.
      step(0, 0, 1);
      s2 = 8'b10101010;
      for (int k = 0; k < 8; k++) begin
         step(s2[7-k], 1, 0);
         check($sformatf("t2_q_bit%0d", k + 1), 32'(q_a[1]), 32'(k == 3 || k == 7));
      end
      settle();
      check("t2_cnt_nov", 32'(cnt_a[1]), 32'd2);
      check("t2_cnt_ov", 32'(cnt_a[0]), 32'd3);

      // 11 must fall back to state 1, not 0.
      step(0, 0, 1);
      e3 = '{0, 1, 1, 2, 3};
      s2 = 8'b11010000;
      for (int k = 0; k < 5; k++) begin
         step(s2[7-k], 1, 0);
         check($sformatf("t3_pst%0d", k), 32'(pst_a[0]), 32'(e3[k]));
      end
      check("t3_q", 32'(q_a[0]), 32'd1);

      // Moore output is delayed by exactly one cycle.
      step(0, 0, 1);
      step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0);
      check("t4_q_early", 32'(q_a[2]), 32'd0);
      settle();
      check("t4_q_late", 32'(q_a[2]), 32'd1);
      check("t4_pst", 32'(pst_a[2]), 32'd2);
      step(0, 0, 0);
      settle();
      check("t4_q_drop", 32'(q_a[2]), 32'd0);

      // en=0 cycles hold the state.
      step(0, 0, 1);
      b5 = 6'b110100;
      e5 = 6'b101101;
      for (int k = 0; k < 6; k++) step(b5[5-k], e5[5-k], 0);
      check("t5_q", 32'(q_a[0]), 32'd1);
      settle();
      check("t5_cnt", 32'(cnt_a[0]), 32'd1);

      // 2-bit counter saturates at 3; then reset mid-pattern.
      step(0, 0, 1);
      e6 = '{1, 2, 3, 3, 3};
      for (int g = 0; g < 5; g++) begin
         step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0);
         settle();
         check($sformatf("t6_cnt%0d", g), 32'(cnt_a[3]), 32'(e6[g]));
         check($sformatf("t6_sat%0d", g), 32'(sat_a[3]), 32'(g >= 2));
         step(0, 1, 0);
      end
      step(1, 1, 0); step(0, 1, 0); step(1, 1, 1);
      settle();
      check("t6_rst_pst", 32'(pst_a[3]), 32'd0);
      check("t6_rst_cnt", 32'(cnt_a[3]), 32'd0);
      check("t6_rst_q", 32'(q_a[3]), 32'd0);
      check("t6_rst_qmoore", 32'(q_a[2]), 32'd0);

      // Random traffic with occasional resets and idle cycles.
      for (int n = 0; n < 3000; n++) begin
         rr = ($urandom_range(0, 99) == 0);
         re = ($urandom_range(0, 9) < 8);
         rb = 1'($urandom_range(0, 1));
         step(rb, re, rr);
      end

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
